// File: rtl/spike_rate_decoder.sv
// Spike decoder: turns a 1-bit spike train back into numbers.
// Rate code = spikes per WINDOW-cycle window, handed off with valid/ack.
// Timing code = inter-spike interval in cycles, flagged by a 1-cycle pulse.
// Both counters saturate at 2^CNT_W-1.
module spike_rate_decoder #(
    parameter int WINDOW = 200,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             spike,
    output logic [CNT_W-1:0] rate,
    output logic             rate_valid,
    input  logic             rate_ack,
    output logic             overrun,
    output logic [CNT_W-1:0] isi,
    output logic             isi_valid
);

    localparam int WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             counting;
    logic             window_end;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] spk_cnt;
    logic [CNT_W-1:0] spk_sum;
    logic [CNT_W-1:0] isi_cnt;
    logic [CNT_W-1:0] isi_inc;
    logic             first_seen;

    // State register: IDLE while disabled, COUNT while decoding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; counting is only true on cycles that actually accumulate.
    always_comb begin
        state_next = state;
        counting   = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (!en) begin
                    state_next = IDLE;
                end else begin
                    counting = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Saturating next values and the last-window-cycle flag.
    always_comb begin
        window_end = counting && (win_cnt == WIN_LAST);
        spk_sum    = (spike && (spk_cnt != CNT_MAX)) ? spk_cnt + CNT_ONE : spk_cnt;
        isi_inc    = (isi_cnt != CNT_MAX) ? isi_cnt + CNT_ONE : isi_cnt;
    end

    // Window and spike counters; held at zero outside COUNT so entry starts clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt <= '0;
            spk_cnt <= '0;
        end else if (!counting) begin
            win_cnt <= '0;
            spk_cnt <= '0;
        end else if (window_end) begin
            win_cnt <= '0;
            spk_cnt <= '0;
        end else begin
            win_cnt <= win_cnt + WIN_W'(1);
            spk_cnt <= spk_sum;
        end
    end

    // Interval tracking; the first spike after entry only arms the measurement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            isi_cnt    <= '0;
            first_seen <= 1'b0;
            isi        <= '0;
            isi_valid  <= 1'b0;
        end else begin
            isi_valid <= 1'b0;
            if (!counting) begin
                isi_cnt    <= '0;
                first_seen <= 1'b0;
            end else if (spike) begin
                isi_cnt    <= CNT_ONE;
                first_seen <= 1'b1;
                if (first_seen) begin
                    isi       <= isi_cnt;
                    isi_valid <= 1'b1;
                end
            end else begin
                isi_cnt <= isi_inc;
            end
        end
    end

    // Rate hand-off: a new sample always wins over a same-cycle ack; losing an unacked one sets overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rate       <= '0;
            rate_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (window_end) begin
            rate       <= spk_sum;
            rate_valid <= 1'b1;
            if (rate_valid && !rate_ack) begin
                overrun <= 1'b1;
            end
        end else if (rate_valid && rate_ack) begin
            rate_valid <= 1'b0;
        end
    end

endmodule
